mem_tile_sequencer: RTL and testbench

- Upstream controller for the master memory address generator.
- Splits a matrix of up to 64x64 elements into tiles of at most ARRAY_DIM x ARRAY_DIM.
- Per tile, issues one start pulse plus base address and row/column extents, waits for the generator's done, then moves to the next tile.
- Signals completion of the whole matrix to the top-level TPU control.

---
 rtl/mem_tile_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_mem_tile_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_tile_sequencer.sv
// Tile sequencer: walks a matrix in ARRAY_DIM-square tiles for the address generator.
// Define SEQ_TIMEOUT_EN to build the WAIT watchdog and sticky err flag.
module mem_tile_sequencer #(
   parameter int unsigned ARRAY_DIM  = 16,
   parameter int unsigned TILE_WORDS = 16,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] mat_base,
   input  logic [6:0] mat_rows,
   input  logic [6:0] mat_cols,
   input  logic       mem_done,
   output logic       mem_active,
   output logic [7:0] mem_base_addr,
   output logic [3:0] mem_num_row,
   output logic [3:0] mem_num_col,
   output logic [1:0] tile_row_idx,
   output logic [1:0] tile_col_idx,
   output logic       busy,
   output logic       all_done,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_NEXT,
      S_FINISH
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] base_q, base_d;
   logic [6:0] rows_q, rows_d;
   logic [6:0] cols_q, cols_d;
   logic [1:0] row_idx_q, row_idx_d;
   logic [1:0] col_idx_q, col_idx_d;
   logic [7:0] addr_q, addr_d;
   logic [3:0] nrow_q, nrow_d;
   logic [3:0] ncol_q, ncol_d;
   logic       active_q, active_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       last_tile;
   logic       col_wrap;

`ifdef SEQ_TIMEOUT_EN
   logic [7:0] wdog_q, wdog_d;
   logic       err_q, err_d;
`endif

   function automatic logic [2:0] tiles(input logic [6:0] n);
      return 3'((32'(n) + ARRAY_DIM - 1) / ARRAY_DIM);
   endfunction

   // Packs {base address, rows-1, cols-1} for tile (ri, ci).
   function automatic logic [15:0] tile_cfg(
      input logic [7:0] b,
      input logic [6:0] r,
      input logic [6:0] c,
      input logic [1:0] ri,
      input logic [1:0] ci
   );
      int unsigned ti, rr, cr;
      ti = 32'(ri) * 32'(tiles(c)) + 32'(ci);
      rr = 32'(r) - 32'(ri) * ARRAY_DIM;
      cr = 32'(c) - 32'(ci) * ARRAY_DIM;
      if (rr > ARRAY_DIM) rr = ARRAY_DIM;
      if (cr > ARRAY_DIM) cr = ARRAY_DIM;
      return {8'(32'(b) + ti * TILE_WORDS), 4'(rr - 1), 4'(cr - 1)};
   endfunction

   assign last_tile = ({1'b0, row_idx_q} + 3'd1 == tiles(rows_q))
                   && ({1'b0, col_idx_q} + 3'd1 == tiles(cols_q));
   assign col_wrap  = ({1'b0, col_idx_q} + 3'd1 == tiles(cols_q));

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      rows_d    = rows_q;
      cols_d    = cols_q;
      row_idx_d = row_idx_q;
      col_idx_d = col_idx_q;
      addr_d    = addr_q;
      nrow_d    = nrow_q;
      ncol_d    = ncol_q;
`ifdef SEQ_TIMEOUT_EN
      wdog_d    = wdog_q;
      err_d     = err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d    = mat_base;
               rows_d    = mat_rows;
               cols_d    = mat_cols;
               row_idx_d = 2'd0;
               col_idx_d = 2'd0;
               if (mat_rows == 7'd0 || mat_cols == 7'd0) begin
                  state_d = S_FINISH;
               end else begin
                  state_d = S_ISSUE;
                  {addr_d, nrow_d, ncol_d} =
                     tile_cfg(mat_base, mat_rows, mat_cols, 2'd0, 2'd0);
               end
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
`ifdef SEQ_TIMEOUT_EN
            wdog_d  = 8'd0;
`endif
         end
         S_WAIT: begin
            if (mem_done) begin
               state_d = S_NEXT;
`ifdef SEQ_TIMEOUT_EN
            end else if (wdog_q == 8'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_FINISH;
            end else begin
               wdog_d  = wdog_q + 8'd1;
`endif
            end
         end
         S_NEXT: begin
            if (last_tile) begin
               state_d = S_FINISH;
            end else begin
               if (col_wrap) begin
                  col_idx_d = 2'd0;
                  row_idx_d = row_idx_q + 2'd1;
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
               state_d = S_ISSUE;
               {addr_d, nrow_d, ncol_d} =
                  tile_cfg(base_q, rows_q, cols_q, row_idx_d, col_idx_d);
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      active_d = (state_d == S_ISSUE);
      done_d   = (state_d == S_FINISH);
      busy_d   = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         base_q    <= '0;
         rows_q    <= '0;
         cols_q    <= '0;
         row_idx_q <= '0;
         col_idx_q <= '0;
         addr_q    <= '0;
         nrow_q    <= '0;
         ncol_q    <= '0;
         active_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
         wdog_q    <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         rows_q    <= rows_d;
         cols_q    <= cols_d;
         row_idx_q <= row_idx_d;
         col_idx_q <= col_idx_d;
         addr_q    <= addr_d;
         nrow_q    <= nrow_d;
         ncol_q    <= ncol_d;
         active_q  <= active_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef SEQ_TIMEOUT_EN
         wdog_q    <= wdog_d;
         err_q     <= err_d;
`endif
      end
   end

   assign mem_active    = active_q;
   assign mem_base_addr = addr_q;
   assign mem_num_row   = nrow_q;
   assign mem_num_col   = ncol_q;
   assign tile_row_idx  = row_idx_q;
   assign tile_col_idx  = col_idx_q;
   assign busy          = busy_q;
   assign all_done      = done_q;

`ifdef SEQ_TIMEOUT_EN
   assign err = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^8'(TIMEOUT);
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_tile_sequencer.sv
// Directed bench for mem_tile_sequencer: tile order, extents, wrap, edge cases.
// Timeout scenario is exercised only when SEQ_TIMEOUT_EN is defined.
module tb_mem_tile_sequencer;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] mat_base;
   logic [6:0] mat_rows;
   logic [6:0] mat_cols;
   logic       mem_done;
   logic       mem_active;
   logic [7:0] mem_base_addr;
   logic [3:0] mem_num_row;
   logic [3:0] mem_num_col;
   logic [1:0] tile_row_idx;
   logic [1:0] tile_col_idx;
   logic       busy;
   logic       all_done;
   logic       err;
   logic [23:0] outs;

   int errors;
   int checks;

   logic [7:0] ob_addr [32];
   logic [3:0] ob_nr [32];
   logic [3:0] ob_nc [32];
   logic [1:0] ob_ri [32];
   logic [1:0] ob_ci [32];
   int n_tiles;
   int n_done;
   int first_done;
   bit timed_out;

   mem_tile_sequencer #(
      .ARRAY_DIM (16),
      .TILE_WORDS(16),
      .TIMEOUT   (10)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .mat_base     (mat_base),
      .mat_rows     (mat_rows),
      .mat_cols     (mat_cols),
      .mem_done     (mem_done),
      .mem_active   (mem_active),
      .mem_base_addr(mem_base_addr),
      .mem_num_row  (mem_num_row),
      .mem_num_col  (mem_num_col),
      .tile_row_idx (tile_row_idx),
      .tile_col_idx (tile_col_idx),
      .busy         (busy),
      .all_done     (all_done),
      .err          (err)
   );

   assign outs = {mem_active, mem_base_addr, mem_num_row, mem_num_col,
                  tile_row_idx, tile_col_idx, busy, all_done, err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [19:0] exp_20x40(input int k);
      case (k)
         0: return {2'd0, 2'd0, 8'h10, 4'd15, 4'd15};
         1: return {2'd0, 2'd1, 8'h20, 4'd15, 4'd15};
         2: return {2'd0, 2'd2, 8'h30, 4'd15, 4'd7};
         3: return {2'd1, 2'd0, 8'h40, 4'd3, 4'd15};
         4: return {2'd1, 2'd1, 8'h50, 4'd3, 4'd15};
         5: return {2'd1, 2'd2, 8'h60, 4'd3, 4'd7};
         default: return '0;
      endcase
   endfunction

   // Runs one matrix, answering each mem_active with mem_done 5 cycles later.
   task automatic run_mat(input logic [7:0] b, input logic [6:0] r,
                          input logic [6:0] c, input bit noise);
      int cnt;
      bit fin;
      n_tiles = 0;
      n_done = 0;
      first_done = -1;
      timed_out = 1'b0;
      fin = 1'b0;
      cnt = 0;
      mat_base = b;
      mat_rows = r;
      mat_cols = c;
      start = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         tick;
         start = 1'b0;
         mem_done = 1'b0;
         if (mem_active) begin
            if (n_tiles < 32) begin
               ob_addr[n_tiles] = mem_base_addr;
               ob_nr[n_tiles] = mem_num_row;
               ob_nc[n_tiles] = mem_num_col;
               ob_ri[n_tiles] = tile_row_idx;
               ob_ci[n_tiles] = tile_col_idx;
            end
            n_tiles++;
            cnt = 5;
            if (noise) begin
               mem_done = 1'b1;
               start = 1'b1;
               mat_base = 8'hAA;
               mat_rows = 7'd64;
               mat_cols = 7'd64;
            end
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) mem_done = 1'b1;
         end
         if (all_done) begin
            n_done++;
            if (first_done < 0) first_done = i;
         end
         if (!busy) begin
            fin = 1'b1;
            break;
         end
      end
      start = 1'b0;
      mem_done = 1'b0;
      if (!fin) timed_out = 1'b1;
   endtask

   task automatic check_20x40(input string tag);
      checks++;
      if (timed_out !== 1'b0 || n_tiles != 6 || n_done != 1) begin
         errors++;
         $display("FAIL %s_count: tiles=%0d done=%0d timeout=%0d, need 6/1/0",
                  tag, n_tiles, n_done, timed_out);
      end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if ({ob_ri[k], ob_ci[k], ob_addr[k], ob_nr[k], ob_nc[k]}
             !== exp_20x40(k)) begin
            errors++;
            $display("FAIL %s_tile%0d: got %h, need %h", tag, k,
                     {ob_ri[k], ob_ci[k], ob_addr[k], ob_nr[k], ob_nc[k]},
                     exp_20x40(k));
         end
      end
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL %s_err: got %b, need 0", tag, err);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      mat_base = 8'h33;
      mat_rows = 7'd20;
      mat_cols = 7'd20;
      for (int i = 0; i < 6; i++) begin
         start = i[0];
         mem_done = ~i[0];
         tick;
         checks++;
         if (outs !== 24'd0) begin
            errors++;
            $display("FAIL reset_outs%0d: got %h, need 000000", i, outs);
         end
      end
      start = 1'b0;
      mem_done = 1'b0;
      reset = 1'b1;
      tick;
      checks++;
      if (busy !== 1'b0 || mem_active !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: busy=%b active=%b, need 0/0",
                  busy, mem_active);
      end
   endtask

   task automatic test_tiles_20x40;
      run_mat(8'h10, 7'd20, 7'd40, 1'b0);
      check_20x40("t20x40");
   endtask

   task automatic test_zero_dims;
      run_mat(8'h10, 7'd0, 7'd20, 1'b0);
      checks++;
      if (timed_out || n_tiles != 0 || n_done != 1 || first_done > 1) begin
         errors++;
         $display("FAIL zero_rows: tiles=%0d done=%0d at=%0d, need 0/1/<=1",
                  n_tiles, n_done, first_done);
      end
      run_mat(8'h10, 7'd30, 7'd0, 1'b0);
      checks++;
      if (timed_out || n_tiles != 0 || n_done != 1 || first_done > 1) begin
         errors++;
         $display("FAIL zero_cols: tiles=%0d done=%0d at=%0d, need 0/1/<=1",
                  n_tiles, n_done, first_done);
      end
   endtask

   task automatic test_wrap_64;
      logic [7:0] ea;
      run_mat(8'hF8, 7'd64, 7'd64, 1'b0);
      checks++;
      if (timed_out || n_tiles != 16 || n_done != 1) begin
         errors++;
         $display("FAIL wrap_count: tiles=%0d done=%0d, need 16/1",
                  n_tiles, n_done);
      end
      checks++;
      if (ob_addr[1] !== 8'h08) begin
         errors++;
         $display("FAIL wrap_tile1: got %h, need 08", ob_addr[1]);
      end
      ea = 8'hF8;
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (ob_addr[k] !== ea || ob_nr[k] !== 4'd15 || ob_nc[k] !== 4'd15
             || ob_ri[k] !== 2'(k / 4) || ob_ci[k] !== 2'(k % 4)) begin
            errors++;
            $display("FAIL wrap_tile%0d: addr=%h r=%0d c=%0d idx=%0d,%0d need %h 15 15",
                     k, ob_addr[k], ob_nr[k], ob_nc[k], ob_ri[k], ob_ci[k], ea);
         end
         ea = ea + 8'h10;
      end
   endtask

   task automatic test_back_to_back;
      mem_done = 1'b1;
      tick;
      mem_done = 1'b0;
      checks++;
      if (busy !== 1'b0 || mem_active !== 1'b0) begin
         errors++;
         $display("FAIL idle_done: busy=%b active=%b, need 0/0",
                  busy, mem_active);
      end
      run_mat(8'h10, 7'd20, 7'd40, 1'b1);
      check_20x40("noise");
   endtask

   task automatic test_midrun_reset;
      int seen;
      int cnt;
      bit hit;
      seen = 0;
      cnt = 0;
      hit = 1'b0;
      mat_base = 8'h10;
      mat_rows = 7'd20;
      mat_cols = 7'd40;
      start = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick;
         start = 1'b0;
         mem_done = 1'b0;
         if (mem_active) begin
            seen++;
            cnt = 5;
            if (seen == 3) begin
               hit = 1'b1;
               break;
            end
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) mem_done = 1'b1;
         end
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL midrun_reach: saw %0d issues, need 3", seen);
      end
      tick;
      checks++;
      if (busy !== 1'b1 || mem_base_addr !== 8'h30) begin
         errors++;
         $display("FAIL midrun_wait: busy=%b addr=%h, need 1/30",
                  busy, mem_base_addr);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (outs !== 24'd0) begin
         errors++;
         $display("FAIL midrun_async: got %h, need 000000", outs);
      end
      tick;
      tick;
      reset = 1'b1;
      tick;
      checks++;
      if (outs !== 24'd0) begin
         errors++;
         $display("FAIL midrun_idle: got %h, need 000000", outs);
      end
      run_mat(8'h00, 7'd16, 7'd16, 1'b0);
      checks++;
      if (timed_out || n_tiles != 1 || n_done != 1
          || {ob_ri[0], ob_ci[0], ob_addr[0], ob_nr[0], ob_nc[0]}
             !== {2'd0, 2'd0, 8'h00, 4'd15, 4'd15}) begin
         errors++;
         $display("FAIL restart_16: tiles=%0d done=%0d addr=%h r=%0d c=%0d, need 1/1/00/15/15",
                  n_tiles, n_done, ob_addr[0], ob_nr[0], ob_nc[0]);
      end
   endtask

`ifdef SEQ_TIMEOUT_EN
   task automatic test_timeout;
      int bad;
      bad = 0;
      mat_base = 8'h00;
      mat_rows = 7'd16;
      mat_cols = 7'd16;
      start = 1'b1;
      tick;
      start = 1'b0;
      checks++;
      if (mem_active !== 1'b1) begin
         errors++;
         $display("FAIL to_issue: active=%b, need 1", mem_active);
      end
      for (int j = 1; j <= 10; j++) begin
         tick;
         if (all_done !== 1'b0 || err !== 1'b0 || busy !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL to_wait: %0d early cycles, need 0", bad);
      end
      tick;
      checks++;
      if (all_done !== 1'b1 || err !== 1'b1) begin
         errors++;
         $display("FAIL to_fire: done=%b err=%b, need 1/1", all_done, err);
      end
      tick;
      checks++;
      if (busy !== 1'b0 || err !== 1'b1 || all_done !== 1'b0) begin
         errors++;
         $display("FAIL to_sticky: busy=%b err=%b done=%b, need 0/1/0",
                  busy, err, all_done);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL to_clear: err=%b, need 0", err);
      end
      tick;
      reset = 1'b1;
      tick;
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b0;
      start = 1'b0;
      mem_done = 1'b0;
      mat_base = '0;
      mat_rows = '0;
      mat_cols = '0;
      test_reset;
      test_tiles_20x40;
      test_zero_dims;
      test_wrap_64;
      test_back_to_back;
      test_midrun_reset;
`ifdef SEQ_TIMEOUT_EN
      test_timeout;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
